rvfi_order_sequencer: RTL and testbench
=======================================

# rvfi_order_sequencer

Reorders RVFI retirement records from an out-of-order or multi-issue core into a strictly increasing `rvfi_order` stream, one record per cycle. Sits between the core's RVFI port and the single-channel instruction/consistency checkers, which require in-order records. Detects duplicate, out-of-window and overflow conditions and flags them as sticky errors for the formal harness to assert on.

## Interface
Parameters:
- `XLEN`, 32, register/address width.
- `ILEN`, 32, instruction width.
- `DEPTH`, 8, reorder window in records; power of two, ≥2.
- `ORDER_W`, 64, width of `rvfi_order`.
- `PKT_W`, derived, width of the packed record: insn, trap, halt, intr, rs1/rs2/rd addr, rs1/rs2 rdata, rd wdata, pc r/wdata, mem addr, r/wmask, r/wdata.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-low.
- `in_valid` in 1: a retirement record is presented this cycle.
- `in_order` in ORDER_W: its `rvfi_order`.
- `in_pkt` in PKT_W: packed record.
- `out_valid` out 1: in-order record valid; no backpressure.
- `out_order` out ORDER_W: order of emitted record.
- `out_pkt` out PKT_W: emitted record.
- `occupancy` out $clog2(DEPTH)+1: records buffered, excluding the output register.
- `err_dup` out 1: sticky, slot already occupied or order already emitted.
- `err_window` out 1: sticky, order ≥ next+DEPTH.

## Operation
- State: `next` (ORDER_W counter, next order to emit), slot table of DEPTH entries {valid, pkt}, output register, error flags.
- Slot index = `in_order[$clog2(DEPTH)-1:0]`.
- Accept rules, evaluated when `in_valid`:
  - `in_order < next`: set `err_dup`, drop.
  - `in_order >= next+DEPTH` (unsigned, no wrap at ORDER_W): set `err_window`, drop.
  - `in_order == next` and slot[next] empty: bypass directly into the output register; slot untouched.
  - `in_order == next` and slot[next] valid: set `err_dup`, drop the input; the buffered record is emitted.
  - Otherwise, if the target slot is valid, set `err_dup` and drop; else write the slot.
- Emit: each cycle, if slot[next] is valid or a bypass occurs, load the output register, clear the slot, and `next <= next+1`; otherwise `out_valid <= 0`. At most one emit per cycle.
- A record arriving for `next+1` in the same cycle that `next` emits is written to the table. It emits the following cycle, giving back-to-back output.
- Errors are sticky until reset. Dropped records never reach the output.
- `occupancy` = count of valid slots. Incremented on a table write and decremented on a table emit in the same cycle, so the net change is 0.

## Timing
- Reset (low at a clock edge): `next=0`, all slots invalid, `out_valid=0`, `out_order=0`, `out_pkt=0`, `occupancy=0`, errors 0. Reset mid-operation discards all buffered records.
- Latency: an in-order record with `in_order==next` appears on `out_valid` the cycle after `in_valid`.
- A buffered record becomes emittable the cycle after its predecessor is emitted.
- Throughput: 1 record/cycle sustained when input arrives in order.
- Outputs are all registered; no combinational path from inputs to outputs.

## Structure
- Package `rvfi_seq_pkg`:
  - `PKT_W` computation function of XLEN/ILEN.
  - Field-offset localparams for pack/unpack.
  - `slot_idx` function.
- Sub-module `rvfi_seq_pack`: combinational pack of RVFI fields into `in_pkt`. Instantiated at the harness, not inside the sequencer.
- Slot table: flop array inside the top module; no RAM macro.

## Test plan
- In-order stream: orders 0,1,2,3 on consecutive cycles → `out_order` 0,1,2,3 on cycles 1–4, `occupancy` stays 0.
- Reversal: orders 3,2,1,0 over four cycles → orders 0,1,2,3 emitted on cycles 4–7 back-to-back, `occupancy` peaks at 3.
- Duplicate: order 2 presented twice while `next=0` → `err_dup=1` after the second, and only one record with order 2 emitted.
- Window: `next=0`, DEPTH=8, order 8 presented → `err_window=1`, nothing buffered, `occupancy=0`.
- Stale: after orders 0,1 are emitted, order 0 presented → `err_dup=1`, `out_valid` stays 0.
- Reset mid-stream: buffer orders 2,3, then assert `reset=0` for one cycle → `occupancy=0`, `next=0`; a subsequent order 0 is emitted 1 cycle later with errors clear.

Source files
------------

// File: rtl/rvfi_order_sequencer_pkg.sv
// rvfi_seq_pkg: shared definitions for the RVFI order sequencer.
//   - fld_e / fld_w / fld_off : packed-record field layout (LSB first)
//   - pkt_w                   : total packed-record width for a given XLEN/ILEN
//   - OFF_* localparams       : field offsets at the default XLEN=32/ILEN=32
//   - slot_idx                : reorder-window slot for an rvfi_order value
package rvfi_seq_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ILEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  // Field order in the packed record, starting at bit 0.
  typedef enum logic [4:0] {
    F_INSN, F_TRAP, F_HALT, F_INTR,
    F_RS1_ADDR, F_RS2_ADDR, F_RD_ADDR,
    F_RS1_RDATA, F_RS2_RDATA, F_RD_WDATA,
    F_PC_RDATA, F_PC_WDATA,
    F_MEM_ADDR, F_MEM_RMASK, F_MEM_WMASK, F_MEM_RDATA, F_MEM_WDATA,
    F_END
  } fld_e;

  function automatic int fld_w(fld_e f, int xlen, int ilen);
    case (f)
      F_INSN:                          return ilen;
      F_TRAP, F_HALT, F_INTR:          return 1;
      F_RS1_ADDR, F_RS2_ADDR, F_RD_ADDR: return REG_ADDR_W;
      F_MEM_RMASK, F_MEM_WMASK:        return xlen / 8;
      default:                         return xlen;
    endcase
  endfunction

  function automatic int fld_off(fld_e f, int xlen, int ilen);
    int off = 0;
    for (int i = 0; i < int'(f); i++) begin
      off += fld_w(fld_e'(i[4:0]), xlen, ilen);
    end
    return off;
  endfunction

  function automatic int pkt_w(int xlen, int ilen);
    return fld_off(F_END, xlen, ilen);
  endfunction

  localparam int OFF_INSN      = fld_off(F_INSN,      XLEN_DEF, ILEN_DEF);
  localparam int OFF_TRAP      = fld_off(F_TRAP,      XLEN_DEF, ILEN_DEF);
  localparam int OFF_HALT      = fld_off(F_HALT,      XLEN_DEF, ILEN_DEF);
  localparam int OFF_INTR      = fld_off(F_INTR,      XLEN_DEF, ILEN_DEF);
  localparam int OFF_RS1_ADDR  = fld_off(F_RS1_ADDR,  XLEN_DEF, ILEN_DEF);
  localparam int OFF_RS2_ADDR  = fld_off(F_RS2_ADDR,  XLEN_DEF, ILEN_DEF);
  localparam int OFF_RD_ADDR   = fld_off(F_RD_ADDR,   XLEN_DEF, ILEN_DEF);
  localparam int OFF_RS1_RDATA = fld_off(F_RS1_RDATA, XLEN_DEF, ILEN_DEF);
  localparam int OFF_RS2_RDATA = fld_off(F_RS2_RDATA, XLEN_DEF, ILEN_DEF);
  localparam int OFF_RD_WDATA  = fld_off(F_RD_WDATA,  XLEN_DEF, ILEN_DEF);
  localparam int OFF_PC_RDATA  = fld_off(F_PC_RDATA,  XLEN_DEF, ILEN_DEF);
  localparam int OFF_PC_WDATA  = fld_off(F_PC_WDATA,  XLEN_DEF, ILEN_DEF);
  localparam int OFF_MEM_ADDR  = fld_off(F_MEM_ADDR,  XLEN_DEF, ILEN_DEF);
  localparam int OFF_MEM_RMASK = fld_off(F_MEM_RMASK, XLEN_DEF, ILEN_DEF);
  localparam int OFF_MEM_WMASK = fld_off(F_MEM_WMASK, XLEN_DEF, ILEN_DEF);
  localparam int OFF_MEM_RDATA = fld_off(F_MEM_RDATA, XLEN_DEF, ILEN_DEF);
  localparam int OFF_MEM_WDATA = fld_off(F_MEM_WDATA, XLEN_DEF, ILEN_DEF);
  localparam int PKT_W_DEF     = pkt_w(XLEN_DEF, ILEN_DEF);

  // Slot is the low log2(depth) bits of the order; depth is a power of two.
  function automatic int unsigned slot_idx(logic [63:0] order, int depth);
    return 32'(order & 64'(depth - 1));
  endfunction

endpackage

// File: rtl/rvfi_order_sequencer_if.sv
// rvfi_seq_if: record stream into and out of the sequencer.
//   in_valid/in_order/in_pkt    : retirement records from the core side
//   out_valid/out_order/out_pkt : in-order records toward the checkers
// master = record source / sink (harness), slave = sequencer.
interface rvfi_seq_if
  import rvfi_seq_pkg::*;
#(
  parameter int ORDER_W = 64,
  parameter int PKT_W   = PKT_W_DEF
) ();

  logic               in_valid;
  logic [ORDER_W-1:0] in_order;
  logic [PKT_W-1:0]   in_pkt;
  logic               out_valid;
  logic [ORDER_W-1:0] out_order;
  logic [PKT_W-1:0]   out_pkt;

  modport master (
    output in_valid, in_order, in_pkt,
    input  out_valid, out_order, out_pkt
  );

  modport slave (
    input  in_valid, in_order, in_pkt,
    output out_valid, out_order, out_pkt
  );

endinterface

// File: rtl/rvfi_order_sequencer_pack.sv
// rvfi_seq_pack: combinational packing of individual RVFI fields into the
// flat record carried by the sequencer. Lives in the harness next to the
// core's RVFI port.
//   inputs : insn, trap, halt, intr, rs1/rs2/rd addr, rs1/rs2 rdata,
//            rd wdata, pc r/wdata, mem addr, mem r/wmask, mem r/wdata
//   output : pkt (pkt_w(XLEN, ILEN) bits, layout from rvfi_seq_pkg)
module rvfi_seq_pack
  import rvfi_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0]       insn,
  input  logic                  trap,
  input  logic                  halt,
  input  logic                  intr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rs1_rdata,
  input  logic [XLEN-1:0]       rs2_rdata,
  input  logic [XLEN-1:0]       rd_wdata,
  input  logic [XLEN-1:0]       pc_rdata,
  input  logic [XLEN-1:0]       pc_wdata,
  input  logic [XLEN-1:0]       mem_addr,
  input  logic [XLEN/8-1:0]     mem_rmask,
  input  logic [XLEN/8-1:0]     mem_wmask,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       mem_wdata,
  output logic [pkt_w(XLEN, ILEN)-1:0] pkt
);

  localparam int O_INSN      = fld_off(F_INSN,      XLEN, ILEN);
  localparam int O_TRAP      = fld_off(F_TRAP,      XLEN, ILEN);
  localparam int O_HALT      = fld_off(F_HALT,      XLEN, ILEN);
  localparam int O_INTR      = fld_off(F_INTR,      XLEN, ILEN);
  localparam int O_RS1_ADDR  = fld_off(F_RS1_ADDR,  XLEN, ILEN);
  localparam int O_RS2_ADDR  = fld_off(F_RS2_ADDR,  XLEN, ILEN);
  localparam int O_RD_ADDR   = fld_off(F_RD_ADDR,   XLEN, ILEN);
  localparam int O_RS1_RDATA = fld_off(F_RS1_RDATA, XLEN, ILEN);
  localparam int O_RS2_RDATA = fld_off(F_RS2_RDATA, XLEN, ILEN);
  localparam int O_RD_WDATA  = fld_off(F_RD_WDATA,  XLEN, ILEN);
  localparam int O_PC_RDATA  = fld_off(F_PC_RDATA,  XLEN, ILEN);
  localparam int O_PC_WDATA  = fld_off(F_PC_WDATA,  XLEN, ILEN);
  localparam int O_MEM_ADDR  = fld_off(F_MEM_ADDR,  XLEN, ILEN);
  localparam int O_MEM_RMASK = fld_off(F_MEM_RMASK, XLEN, ILEN);
  localparam int O_MEM_WMASK = fld_off(F_MEM_WMASK, XLEN, ILEN);
  localparam int O_MEM_RDATA = fld_off(F_MEM_RDATA, XLEN, ILEN);
  localparam int O_MEM_WDATA = fld_off(F_MEM_WDATA, XLEN, ILEN);

  assign pkt[O_INSN      +: ILEN]       = insn;
  assign pkt[O_TRAP]                    = trap;
  assign pkt[O_HALT]                    = halt;
  assign pkt[O_INTR]                    = intr;
  assign pkt[O_RS1_ADDR  +: REG_ADDR_W] = rs1_addr;
  assign pkt[O_RS2_ADDR  +: REG_ADDR_W] = rs2_addr;
  assign pkt[O_RD_ADDR   +: REG_ADDR_W] = rd_addr;
  assign pkt[O_RS1_RDATA +: XLEN]       = rs1_rdata;
  assign pkt[O_RS2_RDATA +: XLEN]       = rs2_rdata;
  assign pkt[O_RD_WDATA  +: XLEN]       = rd_wdata;
  assign pkt[O_PC_RDATA  +: XLEN]       = pc_rdata;
  assign pkt[O_PC_WDATA  +: XLEN]       = pc_wdata;
  assign pkt[O_MEM_ADDR  +: XLEN]       = mem_addr;
  assign pkt[O_MEM_RMASK +: XLEN/8]     = mem_rmask;
  assign pkt[O_MEM_WMASK +: XLEN/8]     = mem_wmask;
  assign pkt[O_MEM_RDATA +: XLEN]       = mem_rdata;
  assign pkt[O_MEM_WDATA +: XLEN]       = mem_wdata;

endmodule

// File: rtl/rvfi_order_sequencer.sv
// rvfi_order_sequencer: reorders RVFI retirement records into a strictly
// increasing rvfi_order stream, one record per cycle, no backpressure.
//   clock      : rising-edge clock
//   reset      : synchronous, active-low
//   bus        : rvfi_seq_if.slave (in_valid/in_order/in_pkt in,
//                out_valid/out_order/out_pkt out, all outputs registered)
//   occupancy  : records held in the slot table (output register excluded)
//   err_dup    : sticky; slot already occupied or order already emitted
//   err_window : sticky; order at or beyond next_order + DEPTH
module rvfi_order_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ILEN    = 32,
  parameter int DEPTH   = 8,
  parameter int ORDER_W = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_seq_if.slave              bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_dup,
  output logic                   err_window
);

  localparam int IW    = $clog2(DEPTH);
  localparam int PKT_W = pkt_w(XLEN, ILEN);

  logic [ORDER_W-1:0] next_order;
  logic [DEPTH-1:0]   slot_v;
  logic [PKT_W-1:0]   slot_pkt [DEPTH];

  logic [IW-1:0]      in_idx;
  logic [IW-1:0]      head_idx;
  logic [ORDER_W:0]   win_end;
  logic               stale;
  logic               beyond;
  logic               at_head;
  logic               head_valid;
  logic               hit;
  logic               bypass;
  logic               write;
  logic               dup_now;
  logic               win_now;
  logic               emit;

  assign in_idx     = IW'(slot_idx(64'(bus.in_order), DEPTH));
  assign head_idx   = next_order[IW-1:0];
  // One extra bit so the window end never wraps at ORDER_W.
  assign win_end    = {1'b0, next_order} + (ORDER_W+1)'(DEPTH);
  assign stale      = bus.in_order < next_order;
  assign beyond     = {1'b0, bus.in_order} >= win_end;
  assign at_head    = bus.in_order == next_order;
  assign head_valid = slot_v[head_idx];
  assign hit        = slot_v[in_idx];

  // An in-window order maps to a unique slot, so an occupied target slot
  // (including the head slot when in_order == next_order) means a duplicate.
  assign bypass  = bus.in_valid & at_head & ~head_valid;
  assign write   = bus.in_valid & ~stale & ~beyond & ~at_head & ~hit;
  assign dup_now = bus.in_valid & (stale | (~beyond & hit));
  assign win_now = bus.in_valid & ~stale & beyond;
  assign emit    = head_valid | bypass;

  // write targets a slot other than the head, so clear and write never collide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      next_order    <= '0;
      slot_v        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_order <= '0;
      bus.out_pkt   <= '0;
      occupancy     <= '0;
      err_dup       <= 1'b0;
      err_window    <= 1'b0;
    end else begin
      if (write)      slot_v[in_idx]   <= 1'b1;
      if (head_valid) slot_v[head_idx] <= 1'b0;
      bus.out_valid <= emit;
      if (emit) begin
        next_order    <= next_order + 1'b1;
        bus.out_order <= next_order;
        bus.out_pkt   <= head_valid ? slot_pkt[head_idx] : bus.in_pkt;
      end
      occupancy  <= occupancy + (IW+1)'(write) - (IW+1)'(head_valid);
      err_dup    <= err_dup | dup_now;
      err_window <= err_window | win_now;
    end
  end

  // Payload storage needs no reset; slot_v qualifies every entry.
  always_ff @(posedge clock) begin
    if (write) slot_pkt[in_idx] <= bus.in_pkt;
  end

endmodule

// File: tb/tb_rvfi_order_sequencer.sv
// Scoreboard bench for rvfi_order_sequencer. The driver builds each record
// through rvfi_seq_pack, runs a reference model keyed by absolute order
// (associative array), and queues the expected post-edge state; a separate
// monitor pops one expectation per cycle and compares.
module tb_rvfi_order_sequencer;
  import rvfi_seq_pkg::*;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int DEPTH   = 8;
  localparam int ORDER_W = 64;
  localparam int PKT_W   = pkt_w(XLEN, ILEN);
  localparam int OCC_W   = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rvfi_seq_if #(.ORDER_W(ORDER_W), .PKT_W(PKT_W)) bus ();
  logic [OCC_W-1:0] occupancy;
  logic             err_dup;
  logic             err_window;

  rvfi_order_sequencer #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .ORDER_W(ORDER_W)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .occupancy(occupancy), .err_dup(err_dup), .err_window(err_window)
  );

  logic [ILEN-1:0]   f_insn;
  logic              f_trap, f_halt, f_intr;
  logic [4:0]        f_rs1_addr, f_rs2_addr, f_rd_addr;
  logic [XLEN-1:0]   f_rs1_rdata, f_rs2_rdata, f_rd_wdata, f_pc_rdata, f_pc_wdata;
  logic [XLEN-1:0]   f_mem_addr, f_mem_rdata, f_mem_wdata;
  logic [XLEN/8-1:0] f_mem_rmask, f_mem_wmask;
  logic [PKT_W-1:0]  pack_pkt;

  rvfi_seq_pack #(.XLEN(XLEN), .ILEN(ILEN)) u_pack (
    .insn(f_insn), .trap(f_trap), .halt(f_halt), .intr(f_intr),
    .rs1_addr(f_rs1_addr), .rs2_addr(f_rs2_addr), .rd_addr(f_rd_addr),
    .rs1_rdata(f_rs1_rdata), .rs2_rdata(f_rs2_rdata), .rd_wdata(f_rd_wdata),
    .pc_rdata(f_pc_rdata), .pc_wdata(f_pc_wdata), .mem_addr(f_mem_addr),
    .mem_rmask(f_mem_rmask), .mem_wmask(f_mem_wmask),
    .mem_rdata(f_mem_rdata), .mem_wdata(f_mem_wdata), .pkt(pack_pkt)
  );

  typedef struct {
    logic             valid;
    bit               chk_data;
    logic [63:0]      order;
    logic [PKT_W-1:0] pkt;
    int               occ;
    logic             dup;
    logic             win;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model state: records buffered by absolute order.
  logic [PKT_W-1:0] buffered [longint unsigned];
  longint unsigned  m_next = 0;
  bit               m_dup  = 0;
  bit               m_win  = 0;

  task automatic chk(input string name, input logic [PKT_W-1:0] act,
                     input logic [PKT_W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic randomize_fields();
    f_insn      = $urandom;
    f_trap      = 1'($urandom);
    f_halt      = 1'($urandom);
    f_intr      = 1'($urandom);
    f_rs1_addr  = 5'($urandom);
    f_rs2_addr  = 5'($urandom);
    f_rd_addr   = 5'($urandom);
    f_rs1_rdata = $urandom;
    f_rs2_rdata = $urandom;
    f_rd_wdata  = $urandom;
    f_pc_rdata  = $urandom;
    f_pc_wdata  = $urandom;
    f_mem_addr  = $urandom;
    f_mem_rmask = 4'($urandom);
    f_mem_wmask = 4'($urandom);
    f_mem_rdata = $urandom;
    f_mem_wdata = $urandom;
  endtask

  // One clock of stimulus plus the model's view of what that edge produces.
  task automatic step(input bit rst, input bit v, input longint unsigned ord);
    exp_t e;
    bit   bypass;
    @(negedge clock);
    randomize_fields();
    #1;
    chk("pack", pack_pkt,
        {f_mem_wdata, f_mem_rdata, f_mem_wmask, f_mem_rmask, f_mem_addr,
         f_pc_wdata, f_pc_rdata, f_rd_wdata, f_rs2_rdata, f_rs1_rdata,
         f_rd_addr, f_rs2_addr, f_rs1_addr, f_intr, f_halt, f_trap, f_insn});
    reset        = ~rst;
    bus.in_valid = v;
    bus.in_order = ord;
    bus.in_pkt   = pack_pkt;
    e.valid    = 1'b0;
    e.chk_data = 1'b0;
    e.order    = '0;
    e.pkt      = '0;
    if (rst) begin
      buffered.delete();
      m_next     = 0;
      m_dup      = 0;
      m_win      = 0;
      e.chk_data = 1'b1;
    end else begin
      bypass = 0;
      if (v) begin
        if (ord < m_next)                m_dup = 1;
        else if (ord >= m_next + DEPTH)  m_win = 1;
        else if (buffered.exists(ord))   m_dup = 1;
        else if (ord == m_next)          bypass = 1;
        else                             buffered[ord] = pack_pkt;
      end
      if (buffered.exists(m_next)) begin
        e.pkt   = buffered[m_next];
        buffered.delete(m_next);
        e.valid = 1'b1;
      end else if (bypass) begin
        e.pkt   = pack_pkt;
        e.valid = 1'b1;
      end
      if (e.valid) begin
        e.order    = m_next;
        e.chk_data = 1'b1;
        m_next++;
      end
    end
    e.occ = buffered.num();
    e.dup = m_dup;
    e.win = m_win;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0);
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid",  PKT_W'(bus.out_valid), PKT_W'(e.valid));
        chk("occupancy",  PKT_W'(occupancy),     PKT_W'(e.occ));
        chk("err_dup",    PKT_W'(err_dup),       PKT_W'(e.dup));
        chk("err_window", PKT_W'(err_window),    PKT_W'(e.win));
        if (e.chk_data) begin
          chk("out_order", PKT_W'(bus.out_order), PKT_W'(e.order));
          chk("out_pkt",   bus.out_pkt,           e.pkt);
        end
      end
    end
  end

  initial begin
    longint unsigned ord;
    int r;
    bus.in_valid = 1'b0;
    bus.in_order = '0;
    bus.in_pkt   = '0;
    do_reset();
    do_reset();

    // in-order stream
    for (int i = 0; i < 4; i++) step(0, 1, i);
    idle(2);

    // reversal
    do_reset();
    for (int i = 3; i >= 0; i--) step(0, 1, i);
    idle(5);

    // duplicate of a buffered order
    do_reset();
    step(0, 1, 2);
    step(0, 1, 2);
    step(0, 1, 0);
    step(0, 1, 1);
    idle(4);

    // out of window, then recovery
    do_reset();
    step(0, 1, DEPTH);
    idle(2);
    step(0, 1, 0);
    idle(2);

    // stale order
    do_reset();
    step(0, 1, 0);
    step(0, 1, 1);
    idle(1);
    step(0, 1, 0);
    idle(2);

    // reset mid-stream
    do_reset();
    step(0, 1, 2);
    step(0, 1, 3);
    do_reset();
    step(0, 1, 0);
    idle(3);

    // randomized mix
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 15) begin
        idle(1);
      end else if (r < 20) begin
        ord = (m_next == 0) ? 0 : m_next - 1 - longint'($urandom_range(0, 3)) % m_next;
        step(0, 1, ord);
      end else if (r < 25) begin
        step(0, 1, m_next + DEPTH + longint'($urandom_range(0, 3)));
      end else begin
        step(0, 1, m_next + longint'($urandom_range(0, DEPTH - 1)));
      end
    end
    idle(DEPTH + 2);

    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
